// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and threshold flags.
// Optional sticky overflow/underflow flags with clear input are built when FIFO_ERR_FLAG_EN is defined.
module param_sync_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       write_en_i,
    input  logic                       read_en_i,
    input  logic [DATA_W-1:0]          data_in_i,
    output logic [DATA_W-1:0]          out_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
`ifdef FIFO_ERR_FLAG_EN
    input  logic                       err_clr_i,
    output logic                       overflow_o,
    output logic                       underflow_o,
`endif
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              wr_ok, rd_ok;

    assign full_o         = (count_q == DEPTH_CNT);
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= AF_CNT);
    assign almost_empty_o = (count_q <= AE_CNT);
    assign count_o        = count_q;
    assign out_o          = out_q;

    // Accepts are gated by the registered flags, so a full FIFO can still read
    // and an empty FIFO can still write in the same cycle.
    assign wr_ok = write_en_i && !full_o;
    assign rd_ok = read_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_d    = out_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            out_d    = mem[rd_ptr_q];
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
        end
    end

    // Storage is intentionally not reset; empty gating keeps stale words off out_o.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= data_in_i;
        end
    end

`ifdef FIFO_ERR_FLAG_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

    // Set conditions are evaluated after clear so they win in the same cycle.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (write_en_i && full_o) begin
            overflow_d = 1'b1;
        end
        if (read_en_i && empty_o) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo at default parameters.
// Error-flag checks are compiled in only when FIFO_ERR_FLAG_EN is defined.
module tb_param_sync_fifo;

    logic       clk_i;
    logic       rst_ni;
    logic       write_en_i;
    logic       read_en_i;
    logic [7:0] data_in_i;
    logic [7:0] out_o;
    logic       full_o;
    logic       empty_o;
    logic       almost_full_o;
    logic       almost_empty_o;
    logic [3:0] count_o;
`ifdef FIFO_ERR_FLAG_EN
    logic       err_clr_i;
    logic       overflow_o;
    logic       underflow_o;
`endif

    int checks;
    int failures;
    logic [7:0] exp_q[$];

    param_sync_fifo dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .write_en_i     (write_en_i),
        .read_en_i      (read_en_i),
        .data_in_i      (data_in_i),
        .out_o          (out_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
`ifdef FIFO_ERR_FLAG_EN
        .err_clr_i      (err_clr_i),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o),
`endif
        .count_o        (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; outputs are checked at the same point.
    task automatic do_op(input logic we, input logic re, input logic [7:0] din);
        write_en_i = we;
        read_en_i  = re;
        data_in_i  = din;
        @(posedge clk_i);
        #1;
        write_en_i = 1'b0;
        read_en_i  = 1'b0;
    endtask

    task automatic fill_1_to_8();
        for (int i = 1; i <= 8; i++) begin
            do_op(1'b1, 1'b0, 8'(i));
            check("fill_count", count_o, i);
            check("fill_af", almost_full_o, (i >= 6));
            check("fill_full", full_o, (i == 8));
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_ni     = 1'b0;
        write_en_i = 1'b0;
        read_en_i  = 1'b0;
        data_in_i  = 8'h00;
`ifdef FIFO_ERR_FLAG_EN
        err_clr_i  = 1'b0;
`endif
        #12;
        check("rst_count", count_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_full", full_o, 0);
        check("rst_ae", almost_empty_o, 1);
        check("rst_af", almost_full_o, 0);
        check("rst_out", out_o, 8'h00);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Fill, then overflow attempt
        fill_1_to_8();
        do_op(1'b1, 1'b0, 8'hFF);
        check("ovf_count", count_o, 8);
        check("ovf_full", full_o, 1);
`ifdef FIFO_ERR_FLAG_EN
        check("ovf_flag", overflow_o, 1);
`endif

        // Drain in order, then underflow attempt
        for (int i = 1; i <= 8; i++) begin
            do_op(1'b0, 1'b1, 8'h00);
            check("drain_out", out_o, i);
            check("drain_count", count_o, 8 - i);
            check("drain_ae", almost_empty_o, ((8 - i) <= 2));
        end
        check("drain_empty", empty_o, 1);
        do_op(1'b0, 1'b1, 8'h00);
        check("udf_out", out_o, 8'h08);
        check("udf_count", count_o, 0);
`ifdef FIFO_ERR_FLAG_EN
        check("udf_flag", underflow_o, 1);
        check("udf_ovf_sticky", overflow_o, 1);
        // Set beats clear: read on empty with err_clr keeps underflow, clears overflow
        err_clr_i = 1'b1;
        do_op(1'b0, 1'b1, 8'h00);
        check("clr_prio_udf", underflow_o, 1);
        check("clr_prio_ovf", overflow_o, 0);
        do_op(1'b0, 1'b0, 8'h00);
        err_clr_i = 1'b0;
        check("clr_udf", underflow_o, 0);
`endif

        // Simultaneous read/write while full: write rejected
        fill_1_to_8();
        do_op(1'b1, 1'b1, 8'hAA);
        check("full_rw_out", out_o, 8'h01);
        check("full_rw_count", count_o, 7);
        for (int i = 2; i <= 8; i++) begin
            do_op(1'b0, 1'b1, 8'h00);
            check("full_rw_drain", out_o, i);
        end
        check("full_rw_empty", empty_o, 1);

        // Simultaneous read/write while empty: no fall-through
        do_op(1'b1, 1'b1, 8'h55);
        check("empty_rw_count", count_o, 1);
        check("empty_rw_out", out_o, 8'h08);
        do_op(1'b0, 1'b1, 8'h00);
        check("empty_rw_read", out_o, 8'h55);
        check("empty_rw_count0", count_o, 0);

        // Mid-occupancy simultaneous accept returns the older word
        do_op(1'b1, 1'b0, 8'h11);
        do_op(1'b1, 1'b0, 8'h22);
        do_op(1'b1, 1'b1, 8'h33);
        check("mid_rw_out", out_o, 8'h11);
        check("mid_rw_count", count_o, 2);
        do_op(1'b0, 1'b1, 8'h00);
        check("mid_rw_next", out_o, 8'h22);
        do_op(1'b0, 1'b1, 8'h00);
        check("mid_rw_last", out_o, 8'h33);

        // Write 5 / read 5, many pointer wraps
        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < 5; k++) begin
                exp_q.push_back(8'((it * 5 + k) ^ 8'hC3));
                do_op(1'b1, 1'b0, exp_q[$]);
            end
            check("wrap_count5", count_o, 5);
            for (int k = 0; k < 5; k++) begin
                do_op(1'b0, 1'b1, 8'h00);
                check("wrap_data", out_o, exp_q.pop_front());
            end
            check("wrap_count0", count_o, 0);
        end

        // Asynchronous reset with entries stored
        for (int k = 0; k < 4; k++) do_op(1'b1, 1'b0, 8'(8'hE0 + k));
        check("prerst_count", count_o, 4);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_count", count_o, 0);
        check("arst_empty", empty_o, 1);
        check("arst_out", out_o, 8'h00);
        #3;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        do_op(1'b0, 1'b1, 8'h00);
        check("post_rst_read_out", out_o, 8'h00);
        check("post_rst_read_cnt", count_o, 0);
        do_op(1'b1, 1'b0, 8'h3C);
        do_op(1'b0, 1'b1, 8'h00);
        check("post_rst_data", out_o, 8'h3C);
        check("post_rst_empty", empty_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
